// File: rtl/cam_cfg_sequencer.sv
// cam_cfg_sequencer: walks a {reg,val} config ROM and issues SCCB writes.
// Optional readback check of every write: define READBACK_VERIFY_EN.
module cam_cfg_sequencer #(
  parameter int unsigned TBL_LEN      = 64,
  parameter int unsigned TICKS_PER_MS = 1000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  tbl_addr,
  input  logic [15:0] tbl_data,
  output logic        wr_req,
  output logic [7:0]  wr_reg,
  output logic [7:0]  wr_val,
  input  logic        wr_ack,
  input  logic        wr_nack,
`ifdef READBACK_VERIFY_EN
  output logic        rd_req,
  output logic [7:0]  rd_reg,
  input  logic [7:0]  rd_data,
  input  logic        rd_ack,
`endif
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  err_index
);

  localparam logic [7:0]  LAST_IDX  = 8'(TBL_LEN - 1);
  localparam logic [15:0] LAST_TICK = 16'(TICKS_PER_MS - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_WAIT_ACK,
    S_VERIFY,
    S_DELAY,
    S_NEXT,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q;
  logic [7:0]  idx_q;
  logic [7:0]  reg_q;
  logic [7:0]  val_q;
  logic        wr_req_q;
  logic        busy_q;
  logic        done_q;
  logic        error_q;
  logic [7:0]  err_idx_q;
  logic [3:0]  retry_q;
  logic [15:0] tick_q;
  logic [7:0]  ms_q;
`ifdef READBACK_VERIFY_EN
  logic        rd_req_q;
`endif

  logic is_end;
  logic is_delay;
  logic zero_delay;
  logic can_retry;
  logic tick_wrap;
  logic last_ms;
  logic last_idx;

  // Classify the ROM word and the counter terminal conditions.
  always_comb begin
    is_end     = (tbl_data == 16'hFFFF);
    is_delay   = (tbl_data[15:8] == 8'hFF) && !is_end;
    zero_delay = (tbl_data[7:0] == 8'h00);
    can_retry  = (retry_q < RETRY_MAX);
    tick_wrap  = (tick_q == LAST_TICK);
    last_ms    = (ms_q == 8'd1);
    last_idx   = (idx_q == LAST_IDX);
  end

  // Sequencer FSM; every output is a register so wr_req is glitch free.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      reg_q     <= 8'd0;
      val_q     <= 8'd0;
      wr_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= 8'd0;
      retry_q   <= 4'd0;
      tick_q    <= 16'd0;
      ms_q      <= 8'd0;
`ifdef READBACK_VERIFY_EN
      rd_req_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q   <= S_FETCH;
            idx_q     <= 8'd0;
            retry_q   <= 4'd0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= 8'd0;
          end
        end
        S_FETCH: begin
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (is_end) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (is_delay) begin
            if (zero_delay) begin
              state_q <= S_NEXT;
            end else begin
              ms_q    <= tbl_data[7:0];
              tick_q  <= 16'd0;
              state_q <= S_DELAY;
            end
          end else begin
            reg_q   <= tbl_data[15:8];
            val_q   <= tbl_data[7:0];
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wr_req_q <= 1'b1;
          state_q  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (wr_nack) begin
            wr_req_q <= 1'b0;
            if (can_retry) begin
              retry_q <= retry_q + 4'd1;
              state_q <= S_ISSUE;
            end else begin
              state_q   <= S_ERROR;
              busy_q    <= 1'b0;
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
            end
          end else if (wr_ack) begin
            wr_req_q <= 1'b0;
`ifdef READBACK_VERIFY_EN
            rd_req_q <= 1'b1;
            state_q  <= S_VERIFY;
`else
            retry_q  <= 4'd0;
            state_q  <= S_NEXT;
`endif
          end
        end
        S_VERIFY: begin
`ifdef READBACK_VERIFY_EN
          if (rd_ack) begin
            rd_req_q <= 1'b0;
            if (rd_data == val_q) begin
              retry_q <= 4'd0;
              state_q <= S_NEXT;
            end else if (can_retry) begin
              retry_q <= retry_q + 4'd1;
              state_q <= S_ISSUE;
            end else begin
              state_q   <= S_ERROR;
              busy_q    <= 1'b0;
              error_q   <= 1'b1;
              err_idx_q <= idx_q;
            end
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_DELAY: begin
          if (tick_wrap) begin
            tick_q <= 16'd0;
            if (last_ms) begin
              state_q <= S_NEXT;
            end else begin
              ms_q <= ms_q - 8'd1;
            end
          end else begin
            tick_q <= tick_q + 16'd1;
          end
        end
        S_NEXT: begin
          if (last_idx) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + 8'd1;
            state_q <= S_FETCH;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tbl_addr  = idx_q;
  assign wr_req    = wr_req_q;
  assign wr_reg    = reg_q;
  assign wr_val    = val_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_idx_q;
`ifdef READBACK_VERIFY_EN
  assign rd_req    = rd_req_q;
  assign rd_reg    = reg_q;
`endif

endmodule

// File: doc/cam_cfg_sequencer.md
Name: cam_cfg_sequencer

Overview:
Sequences power-up register configuration of the camera sensor over the SCCB/I2C link. Walks a synchronous configuration ROM of {register, value} entries and hands each write to the existing byte-write I2C master through a req/ack handshake. Supports delay entries, early end markers and bounded retry on NACK, and reports busy/done/error status to LEDs and the top level. Sits between the 1 MHz I2C clock domain logic and the camera I2C master; runs entirely on clk.

Parameters:
TBL_LEN, 64, number of ROM entries, 1..256
TICKS_PER_MS, 1000, clk cycles per millisecond (1 MHz clk)
MAX_RETRY, 3, extra attempts after a NACK before error, 0..15

Ports:
clk  in  1  sequencer clock (i2c_clk)
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins/restarts sequence from entry 0 when idle, done or error
tbl_addr  out  8  ROM address
tbl_data  in  16  ROM data {reg[15:8], val[7:0]}, valid 1 cycle after tbl_addr
wr_req  out  1  write request to I2C master
wr_reg  out  8  register address, stable while wr_req=1
wr_val  out  8  register value, stable while wr_req=1
wr_ack  in  1  one-cycle pulse: write accepted by slave
wr_nack  in  1  one-cycle pulse: slave NACK / bus error
busy  out  1  sequence in progress
done  out  1  sequence completed, held until next start
error  out  1  retry budget exhausted, held until next start
err_index  out  8  entry index that failed; 0 when error=0

Behaviour:
- Reset: all outputs 0; state IDLE; retry count, delay counters, index cleared. Reset mid-sequence aborts immediately; wr_req drops asynchronously.
- States: IDLE, FETCH, DECODE, ISSUE, WAIT_ACK, DELAY, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR + start -> FETCH; index=0, done/error/err_index cleared, busy=1 from cycle after start.
- start while busy ignored.
- FETCH: tbl_addr=index, 1 cycle -> DECODE (ROM latency 1).
- DECODE on tbl_data:
  - 0xFFFF = end marker -> DONE.
  - 0xFFnn with nn != 0xFF = delay nn ms -> DELAY; nn=0 -> NEXT with no wait.
  - otherwise latch reg/val -> ISSUE.
- ISSUE: wr_req=1 next cycle -> WAIT_ACK. wr_req/wr_reg/wr_val stay constant until ack or nack is sampled.
- WAIT_ACK:
  - wr_ack -> wr_req=0, retry=0 -> NEXT.
  - wr_nack -> wr_req=0. If retry<MAX_RETRY: retry++, back to ISSUE (min 1 idle cycle between requests). Else -> ERROR, err_index=index.
  - ack and nack in the same cycle: treat as nack.
- DELAY: count nn*TICKS_PER_MS cycles using a 16-bit tick counter and an 8-bit ms counter -> NEXT.
- NEXT: if index==TBL_LEN-1 -> DONE; else index++ -> FETCH. Index never wraps.
- DONE: busy=0, done=1. ERROR: busy=0, error=1. done and error are never both 1.
- Minimum cost per write entry: FETCH+DECODE+ISSUE+ack latency+NEXT.

Optional Feature:
READBACK_VERIFY_EN. Defined:
- Adds ports rd_req (out 1), rd_reg (out 8), rd_data (in 8), rd_ack (in 1).
- After each wr_ack, enters VERIFY: asserts rd_req with rd_reg=reg, held until rd_ack.
- rd_data==val -> NEXT. Mismatch counts as a NACK and uses the same retry/ERROR path, restarting with the write.
- rd_req=0 in reset.

Undefined: ports absent, wr_ack goes straight to NEXT.

Test Plan:
- Table {0x1280, 0x1101, 0xFFFF}, start, acks after 5 cycles -> exactly two wr_req transactions (0x12/0x80, 0x11/0x01), then done=1, busy=0, error=0.
- Entry 0xFF02 with TICKS_PER_MS=10 -> zero wr_req for 20 cycles (±2 for state overhead) before next entry fetch.
- MAX_RETRY=2, entry 3 always NACKs -> 3 identical requests, then error=1, err_index=3, done=0, no further wr_req.
- NACK once then ACK -> 2 requests for the same entry, sequence completes, done=1.
- No end marker, TBL_LEN=4 -> exactly 4 writes, tbl_addr never exceeds 3, done=1.
- Assert reset_n=0 while wr_req=1 -> wr_req=0 immediately; after release, idle until start, then full sequence replays from entry 0.
